// File: rtl/mac_stream_engine.sv
// mac_stream_engine: streaming N-lane dot-product engine.
// Three pipeline stages: multiply, then adder-tree reduce, then accumulate and clamp.
// The engine emits one saturated result per burst over a valid/ready output.
module mac_stream_engine #(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DW-1:0]     in_a,
    input  logic [N*DW-1:0]     in_b,
    input  logic                in_last,
    input  logic                in_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat,
    output logic [CNT_W-1:0]    out_beats
);

    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned SW    = PW + $clog2(N);
    localparam int unsigned ACC_W = SW + CNT_W;

    localparam logic [ACC_W-1:0] UMAX = ACC_W'({OUT_W{1'b1}});
    localparam logic [ACC_W-1:0] SMAX = ACC_W'({(OUT_W-1){1'b1}});
    localparam logic [ACC_W-1:0] SMIN = ~SMAX;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic                adv;
    logic                take;

    // Input-side burst tracking: mode latch and beat count for forced termination
    logic [CNT_W-1:0]    icnt_q;
    logic                mode_q;
    logic [CNT_W-1:0]    icnt_nxt;
    logic                mode_d;
    logic                last_d;

    logic [PW-1:0]       prod_d [N];
    logic [PW-1:0]       prod1  [N];
    logic                v1, last1, mode1;

    logic [SW-1:0]       sum_d;
    logic [SW-1:0]       sum2;
    logic                v2, last2, mode2;

    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ACC_W-1:0]    acc_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [OUT_W-1:0]    data_d;
    logic                sat_d;

    // Whole pipeline advances unless a held result is blocking the output
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign take     = in_valid && adv;

    // Beat mode comes from the first beat; a full counter forces a burst end
    always_comb begin
        mode_d   = (icnt_q == '0) ? in_signed : mode_q;
        icnt_nxt = icnt_q + CNT_W'(1);
        last_d   = in_last || (icnt_nxt == CMAX);
    end

    // Lane multipliers on operands extended to product width
    always_comb begin
        for (int i = 0; i < N; i++) begin
            logic [PW-1:0] ea;
            logic [PW-1:0] eb;
            if (mode_d) begin
                ea = {{DW{in_a[i*DW+DW-1]}}, in_a[i*DW +: DW]};
                eb = {{DW{in_b[i*DW+DW-1]}}, in_b[i*DW +: DW]};
            end else begin
                ea = {{DW{1'b0}}, in_a[i*DW +: DW]};
                eb = {{DW{1'b0}}, in_b[i*DW +: DW]};
            end
            prod_d[i] = ea * eb;
        end
    end

    // Input tracking registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_q <= '0;
            mode_q <= 1'b0;
        end else if (take) begin
            icnt_q <= last_d ? '0 : icnt_nxt;
            mode_q <= mode_d;
        end
    end

    // S1: registered products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) prod1[i] <= '0;
            v1    <= 1'b0;
            last1 <= 1'b0;
            mode1 <= 1'b0;
        end else if (adv) begin
            v1 <= take;
            if (take) begin
                for (int i = 0; i < N; i++) prod1[i] <= prod_d[i];
                last1 <= last_d;
                mode1 <= mode_d;
            end
        end
    end

    // Adder tree over products, extended per mode
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            if (mode1) sum_d = sum_d + {{(SW-PW){prod1[i][PW-1]}}, prod1[i]};
            else       sum_d = sum_d + {{(SW-PW){1'b0}}, prod1[i]};
        end
    end

    // S2: registered lane sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum2  <= '0;
            v2    <= 1'b0;
            last2 <= 1'b0;
            mode2 <= 1'b0;
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                sum2  <= sum_d;
                last2 <= last1;
                mode2 <= mode1;
            end
        end
    end

    // Next accumulator value and its clamped output form
    always_comb begin
        if (mode2) acc_nxt = acc_q + {{(ACC_W-SW){sum2[SW-1]}}, sum2};
        else       acc_nxt = acc_q + {{(ACC_W-SW){1'b0}}, sum2};
        cnt_nxt = cnt_q + CNT_W'(1);
        data_d  = acc_nxt[OUT_W-1:0];
        sat_d   = 1'b0;
        if (mode2) begin
            if ($signed(acc_nxt) > $signed(SMAX)) begin
                data_d = SMAX[OUT_W-1:0];
                sat_d  = 1'b1;
            end else if ($signed(acc_nxt) < $signed(SMIN)) begin
                data_d = SMIN[OUT_W-1:0];
                sat_d  = 1'b1;
            end
        end else if (acc_nxt > UMAX) begin
            data_d = UMAX[OUT_W-1:0];
            sat_d  = 1'b1;
        end
    end

    // S3: accumulate and publish one result per burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_beats <= '0;
        end else if (adv) begin
            out_valid <= 1'b0;
            if (v2) begin
                if (last2) begin
                    out_valid <= 1'b1;
                    out_data  <= data_d;
                    out_sat   <= sat_d;
                    out_beats <= cnt_nxt;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                end else begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_stream_engine.sv
// tb_mac_stream_engine: randomized bench with a burst-level reference model.
module tb_mac_stream_engine;

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned MAXB  = 255;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N*DW-1:0]     in_a = '0;
    logic [N*DW-1:0]     in_b = '0;
    logic                in_last = 1'b0;
    logic                in_signed = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [OUT_W-1:0]    out_data;
    logic                out_sat;
    logic [CNT_W-1:0]    out_beats;

    int n_checks = 0;
    int n_fail   = 0;
    int or_mode  = 0;

    // Reference model state: expected results in burst order
    longint m_acc  = 0;
    int     m_cnt  = 0;
    bit     m_mode = 1'b0;
    longint exp_data[$];
    longint exp_sat[$];
    longint exp_beats[$];

    mac_stream_engine #(.N(N), .DW(DW), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_beats(out_beats)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint dot(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input bit s);
        longint r = 0;
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] la;
            logic [DW-1:0] lb;
            longint ia;
            longint ib;
            la = a[i*DW +: DW];
            lb = b[i*DW +: DW];
            ia = s ? longint'($signed(la)) : longint'(la);
            ib = s ? longint'($signed(lb)) : longint'(lb);
            r += ia * ib;
        end
        return r;
    endfunction

    // Close a burst in the model: clamp the full-precision sum
    task automatic model_emit();
        longint d;
        longint s;
        longint umax = (longint'(1) << OUT_W) - 1;
        longint smax = (longint'(1) << (OUT_W - 1)) - 1;
        longint smin = -(longint'(1) << (OUT_W - 1));
        s = 0;
        if (m_mode) begin
            if (m_acc > smax)      begin d = smax; s = 1; end
            else if (m_acc < smin) begin d = smin; s = 1; end
            else d = m_acc;
        end else begin
            if (m_acc > umax) begin d = umax; s = 1; end
            else d = m_acc;
        end
        exp_data.push_back(d & umax);
        exp_sat.push_back(s);
        exp_beats.push_back(m_cnt);
        m_acc = 0;
        m_cnt = 0;
    endtask

    // Present one beat until accepted, then fold it into the model
    task automatic drive_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                              input bit last, input bit sgn);
        bit rdy;
        int tries;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_last   = last;
        in_signed = sgn;
        rdy = 1'b0;
        tries = 0;
        while (!rdy && tries < 1000) begin
            @(negedge clk);
            #1 rdy = in_ready;
            @(posedge clk);
            tries++;
        end
        #1 in_valid = 1'b0;
        check_eq("in_ready_timeout", rdy, 1);
        if (m_cnt == 0) m_mode = sgn;
        m_acc += dot(a, b, m_mode);
        m_cnt++;
        if (last || m_cnt == MAXB) model_emit();
    endtask

    function automatic logic [N*DW-1:0] lanes(input int l0, input int l1, input int l2, input int l3);
        return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
    endfunction

    // Output ready pattern: 0 always ready, 1 random, 2 held low
    always @(negedge clk) begin
        if (or_mode == 0)      out_ready = 1'b1;
        else if (or_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else                   out_ready = 1'b0;
    end

    // Output monitor: in-order scoreboard plus hold-stability under backpressure
    bit               hold = 1'b0;
    logic [OUT_W-1:0] h_data;
    logic             h_sat;
    logic [CNT_W-1:0] h_beats;
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, h_data);
                check_eq("hold_sat", out_sat, h_sat);
                check_eq("hold_beats", out_beats, h_beats);
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    check_eq("spurious_out", exp_data.size(), 1);
                end else begin
                    check_eq("out_data", out_data, exp_data.pop_front());
                    check_eq("out_sat", out_sat, exp_sat.pop_front());
                    check_eq("out_beats", out_beats, exp_beats.pop_front());
                end
            end
            hold    = out_valid && !out_ready;
            h_data  = out_data;
            h_sat   = out_sat;
            h_beats = out_beats;
        end
    end

    task automatic drain();
        int c = 0;
        while ((exp_data.size() != 0 || out_valid) && c < 2000) begin
            @(posedge clk);
            #1 c++;
        end
        check_eq("drain_pending", exp_data.size(), 0);
    endtask

    initial begin
        int lat;
        bit saw_stall;

        // Reset state
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_sat", out_sat, 0);
        check_eq("rst_out_beats", out_beats, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Unsigned single beat and its latency
        drive_beat(lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 1'b1, 1'b0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check_eq("latency", lat, 3);
        drain();

        // Unsigned saturation, signed result, signed saturation
        drive_beat(lanes(127, 127, 127, 127), lanes(127, 127, 127, 127), 1'b0, 1'b0);
        drive_beat(lanes(127, 127, 127, 127), lanes(127, 127, 127, 127), 1'b1, 1'b0);
        drive_beat(lanes(-1, -2, -3, -4), lanes(5, 6, 7, 8), 1'b1, 1'b1);
        drive_beat(lanes(-128, -128, -128, -128), lanes(-128, -128, -128, -128), 1'b1, 1'b1);
        // in_signed toggled mid-burst must not change the burst mode
        drive_beat(lanes(255, 0, 0, 0), lanes(1, 0, 0, 0), 1'b0, 1'b0);
        drive_beat(lanes(255, 0, 0, 0), lanes(1, 0, 0, 0), 1'b0, 1'b1);
        drive_beat(lanes(255, 0, 0, 0), lanes(1, 0, 0, 0), 1'b1, 1'b1);
        drain();

        // Backpressure: ten 1-beat bursts with a 5-cycle output stall
        saw_stall = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++)
                    drive_beat(lanes(k, 0, 0, 0), lanes(1, 0, 0, 0), 1'b1, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                or_mode = 2;
                repeat (5) begin
                    @(negedge clk);
                    #1 if (!in_ready) saw_stall = 1'b1;
                end
                or_mode = 0;
            end
        join
        check_eq("stall_in_ready_low", saw_stall, 1);
        drain();

        // Length boundary: forced termination, then a fresh burst
        or_mode = 1;
        for (int k = 0; k < int'(MAXB); k++)
            drive_beat(lanes(1, 0, 0, 0), lanes(1, 0, 0, 0), 1'b0, 1'b0);
        drive_beat(lanes(2, 0, 0, 0), lanes(1, 0, 0, 0), 1'b1, 1'b0);
        drain();

        // Randomized bursts with random mode toggling and random output ready
        for (int k = 0; k < 40; k++) begin
            int len;
            bit md;
            len = $urandom_range(1, 6);
            md  = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++)
                drive_beat($urandom, $urandom, (j == len - 1),
                           (j == 0) ? md : 1'($urandom_range(0, 1)));
        end
        drain();
        or_mode = 0;

        // Reset mid-burst discards the partial burst
        drive_beat(lanes(9, 9, 9, 9), lanes(9, 9, 9, 9), 1'b0, 1'b0);
        drive_beat(lanes(9, 9, 9, 9), lanes(9, 9, 9, 9), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_data", out_data, 0);
        check_eq("midrst_out_sat", out_sat, 0);
        check_eq("midrst_out_beats", out_beats, 0);
        m_acc = 0;
        m_cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_beat(lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1, 1'b0);
        drain();
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
